tri_bus_sampler: RTL and testbench
==================================

Name: tri_bus_sampler

Overview:
- Input-side counterpart to the tristate LED/bus driver tests on the hx8k-b-evn board.
- Samples an 8-line shared bus whose pads are pulled up. Each line is either driven by a peer or released (high-Z, reads 1).
- Synchronises and debounces the lines and distinguishes "bus released" (all ones) from a driven data word.
- Hands each new stable driven word to downstream logic through a valid/ack handshake.

Parameters:
- WIDTH, 8: number of bus lines.
- STABLE_CYCLES, 256: consecutive hwclk cycles a synchronised value must hold before it is accepted. Must be ≥2. The counter width is clog2(STABLE_CYCLES).

Ports:
- hwclk  input  1  system clock; all logic on rising edge.
- reset_n  input  1  synchronous, active-low reset.
- pins_in  input  WIDTH  raw bus lines from SB_IO D_IN_0 (PULLUP=1); asynchronous to hwclk.
- data  output  WIDTH  last accepted driven word.
- data_valid  output  1  high while data holds an unacknowledged word.
- data_ack  input  1  consumer accepts data; only meaningful while data_valid=1.
- bus_released  output  1  high while the accepted bus value is all ones.
- overrun  output  1  sticky; a driven word was dropped because the previous one was unacknowledged.

Behaviour:
- Reset (reset_n=0 at a rising edge):
  - sync stages, candidate and stable value set to all ones; counter=0.
  - data=0, data_valid=0, bus_released=1, overrun=0.
  - Reset mid-settling discards the candidate. Reset while data_valid=1 discards the pending word.
- Synchroniser: two flops per line (sync1←pins_in, sync2←sync1). No other path from pins_in.
- Settling, every cycle:
  - If sync2≠candidate: candidate←sync2, counter←0.
  - Else if counter<STABLE_CYCLES−1: counter←counter+1.
  - Else (counter=STABLE_CYCLES−1) and candidate≠stable: commit (below). The counter holds at STABLE_CYCLES−1 until the candidate changes.
- Latency: pins_in changes and is held from the rising edge E1 that captures it into sync1. The commit takes effect at edge E(STABLE_CYCLES+3), so outputs change immediately after that edge.
- Glitch filtering: any value held in sync2 for fewer than STABLE_CYCLES consecutive cycles is never committed. A return to the current stable value before commit produces no event.
- Commit actions:
  - stable←candidate.
  - If candidate is all ones: bus_released←1. data, data_valid and overrun are unchanged; release is not a data word.
  - Else, bus_released←0, then:
    - data_valid=0: data←candidate, data_valid←1.
    - data_valid=1 and data_ack=1 this cycle: data←candidate, data_valid stays 1, no overrun.
    - data_valid=1 and data_ack=0: word dropped (data unchanged), overrun←1.
- Handshake:
  - data_ack=1 while data_valid=1 with no same-cycle commit: data_valid←0 on that edge. data is retained, not cleared.
  - data_ack while data_valid=0 is ignored.
  - data_valid never drops without an ack or a reset.
- Repeated values: driven word A → released → A again yields two separate data words. Driven A → driven B directly yields a B word; bus_released stays 0 throughout.
- overrun: cleared only by reset.
- Widths: all comparisons are full WIDTH. No arithmetic on data.

Test Plan (STABLE_CYCLES=4, WIDTH=8 unless noted):
1. Reset, pins_in=0xFF constant → data=0x00, data_valid=0, bus_released=1, overrun=0 indefinitely.
2. pins_in 0xFF→0x5A captured at edge E1 and held → data=0x5A, data_valid=1, bus_released=0 right after edge E7 (not earlier). Ack one cycle → data_valid=0, data stays 0x5A.
3. pins_in=0x3C for 3 cycles then back to 0xFF → no data_valid, bus_released stays 1.
4. 0x11 committed, not acked; then 0x22 held → data stays 0x11, data_valid=1, overrun=1. Ack → data_valid=0, overrun stays 1.
5. 0x11 pending; drive 0x22 so its commit edge coincides with data_ack=1 → data=0x22, data_valid=1 continuously, overrun=0.
6. reset_n=0 for one edge while 0x7E is mid-settling (counter=2) → all outputs at reset values. If 0x7E is still held, it commits at STABLE_CYCLES+3 edges after reset release.

Source files
------------

// File: rtl/tri_bus_sampler.sv
// Samples a pulled-up shared bus: synchronises, debounces, separates "released" (all ones)
// from driven words, and hands each new driven word downstream through valid/ack.
module tri_bus_sampler #(
    parameter int WIDTH         = 8,
    parameter int STABLE_CYCLES = 256
) (
    input  logic             hwclk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] pins_in,
    output logic [WIDTH-1:0] data,
    output logic             data_valid,
    input  logic             data_ack,
    output logic             bus_released,
    output logic             overrun
);

    localparam int            CW      = $clog2(STABLE_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES - 1);

    logic [WIDTH-1:0] sync_p0;
    logic [WIDTH-1:0] sync_p1;
    logic [WIDTH-1:0] cand;
    logic [WIDTH-1:0] stable;
    logic [CW-1:0]    count;
    logic             cand_ones;
    logic             commit;
    logic             commit_word;

    always_comb begin
        cand_ones   = &cand;
        commit      = (sync_p1 == cand) && (count == CNT_MAX) && (cand != stable);
        commit_word = commit && !cand_ones;
    end

    always_ff @(posedge hwclk) begin
        if (!reset_n) begin
            sync_p0      <= '1;
            sync_p1      <= '1;
            cand         <= '1;
            stable       <= '1;
            count        <= '0;
            data         <= '0;
            data_valid   <= 1'b0;
            bus_released <= 1'b1;
            overrun      <= 1'b0;
        end else begin
            // synchroniser -> settling stage
            sync_p0 <= pins_in;
            sync_p1 <= sync_p0;

            if (sync_p1 != cand) begin
                cand  <= sync_p1;
                count <= '0;
            end else if (count != CNT_MAX) begin
                count <= count + CW'(1);
            end

            // commit / handshake stage
            if (commit) begin
                stable       <= cand;
                bus_released <= cand_ones;
            end

            // A release commit is not a data word, so an ack in that cycle is still honoured.
            if (commit_word) begin
                if (!data_valid || data_ack) begin
                    data       <= cand;
                    data_valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (data_valid && data_ack) begin
                data_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_tri_bus_sampler.sv
// Directed bench for tri_bus_sampler with STABLE_CYCLES=4: commit lands 7 edges after a pin change.
module tb_tri_bus_sampler;

    logic       hwclk;
    logic       reset_n;
    logic [7:0] pins_in;
    logic [7:0] data;
    logic       data_valid;
    logic       data_ack;
    logic       bus_released;
    logic       overrun;

    int vectors;
    int miscompares;

    tri_bus_sampler #(.WIDTH(8), .STABLE_CYCLES(4)) dut (
        .hwclk        (hwclk),
        .reset_n      (reset_n),
        .pins_in      (pins_in),
        .data         (data),
        .data_valid   (data_valid),
        .data_ack     (data_ack),
        .bus_released (bus_released),
        .overrun      (overrun)
    );

    initial hwclk = 1'b0;
    always #5 hwclk = ~hwclk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish before 200000");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge hwclk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic expect_out(input string tag, input logic [7:0] d, input logic v,
                              input logic br, input logic ov);
        chk({tag, ".data"}, data, d);
        chk({tag, ".valid"}, {7'b0, data_valid}, {7'b0, v});
        chk({tag, ".released"}, {7'b0, bus_released}, {7'b0, br});
        chk({tag, ".overrun"}, {7'b0, overrun}, {7'b0, ov});
    endtask

    // Tick n edges, checking the same expected outputs after each one.
    task automatic hold(input string tag, input int n, input logic [7:0] d, input logic v,
                        input logic br, input logic ov);
        for (int i = 0; i < n; i++) begin
            tick();
            expect_out(tag, d, v, br, ov);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset_n     = 1'b0;
        pins_in     = 8'hFF;
        data_ack    = 1'b0;

        // 1: reset state, released bus, stray acks ignored
        tick();
        tick();
        expect_out("reset", 8'h00, 1'b0, 1'b1, 1'b0);
        reset_n = 1'b1;
        hold("idle", 4, 8'h00, 1'b0, 1'b1, 1'b0);
        data_ack = 1'b1;
        hold("idle_ack", 3, 8'h00, 1'b0, 1'b1, 1'b0);
        data_ack = 1'b0;
        hold("idle2", 3, 8'h00, 1'b0, 1'b1, 1'b0);

        // 2: 0x5A commits exactly at E7, then ack keeps data
        pins_in = 8'h5A;
        hold("5a_settle", 6, 8'h00, 1'b0, 1'b1, 1'b0);
        tick();
        expect_out("5a_commit", 8'h5A, 1'b1, 1'b0, 1'b0);
        data_ack = 1'b1;
        tick();
        data_ack = 1'b0;
        expect_out("5a_ack", 8'h5A, 1'b0, 1'b0, 1'b0);

        // release, then 3: 0x3C glitch of 3 cycles is filtered
        pins_in = 8'hFF;
        hold("rel_settle", 6, 8'h5A, 1'b0, 1'b0, 1'b0);
        tick();
        expect_out("rel_commit", 8'h5A, 1'b0, 1'b1, 1'b0);
        pins_in = 8'h3C;
        tick(); tick(); tick();
        pins_in = 8'hFF;
        hold("glitch", 10, 8'h5A, 1'b0, 1'b1, 1'b0);

        // 4: unacked 0x11 then 0x22 -> overrun, data kept
        pins_in = 8'h11;
        hold("11_settle", 6, 8'h5A, 1'b0, 1'b1, 1'b0);
        tick();
        expect_out("11_commit", 8'h11, 1'b1, 1'b0, 1'b0);
        pins_in = 8'h22;
        hold("22_settle", 6, 8'h11, 1'b1, 1'b0, 1'b0);
        tick();
        expect_out("22_drop", 8'h11, 1'b1, 1'b0, 1'b1);
        data_ack = 1'b1;
        tick();
        data_ack = 1'b0;
        expect_out("22_ack", 8'h11, 1'b0, 1'b0, 1'b1);

        // overrun only clears on reset
        pins_in = 8'hFF;
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        expect_out("reset2", 8'h00, 1'b0, 1'b1, 1'b0);

        // 5: ack coincides with the next commit -> replace, no overrun
        pins_in = 8'h11;
        hold("11b_settle", 6, 8'h00, 1'b0, 1'b1, 1'b0);
        tick();
        expect_out("11b_commit", 8'h11, 1'b1, 1'b0, 1'b0);
        pins_in = 8'h22;
        hold("22b_settle", 6, 8'h11, 1'b1, 1'b0, 1'b0);
        data_ack = 1'b1;
        tick();
        data_ack = 1'b0;
        expect_out("22b_replace", 8'h22, 1'b1, 1'b0, 1'b0);
        hold("22b_hold", 2, 8'h22, 1'b1, 1'b0, 1'b0);

        // 6: reset while 0x7E is mid-settling (counter=2)
        pins_in = 8'h7E;
        hold("7e_pre", 5, 8'h22, 1'b1, 1'b0, 1'b0);
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        expect_out("7e_reset", 8'h00, 1'b0, 1'b1, 1'b0);
        hold("7e_settle", 6, 8'h00, 1'b0, 1'b1, 1'b0);
        tick();
        expect_out("7e_commit", 8'h7E, 1'b1, 1'b0, 1'b0);

        // same word after a release is a fresh event
        data_ack = 1'b1;
        tick();
        data_ack = 1'b0;
        expect_out("7e_ack", 8'h7E, 1'b0, 1'b0, 1'b0);
        pins_in = 8'hFF;
        hold("7e_rel_settle", 6, 8'h7E, 1'b0, 1'b0, 1'b0);
        tick();
        expect_out("7e_rel", 8'h7E, 1'b0, 1'b1, 1'b0);
        pins_in = 8'h7E;
        hold("7e_again_settle", 6, 8'h7E, 1'b0, 1'b1, 1'b0);
        tick();
        expect_out("7e_again", 8'h7E, 1'b1, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
